// File: rtl/spi_txn_scheduler.sv
// Multi-word SPI transaction sequencer for a single-byte spi_controller.
// Two requesters share the controller under round-robin arbitration.
module spi_txn_scheduler #(
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [1:0]             req_start,
  input  logic [2*LEN_BITS-1:0]  req_len,
  input  logic [1:0]             tx_valid,
  input  logic [2*DATA_BITS-1:0] tx_data,
  output logic [1:0]             tx_ready,
  output logic [1:0]             rx_valid,
  output logic [DATA_BITS-1:0]   rx_data,
  output logic [1:0]             busy,
  output logic [1:0]             done,
  output logic                   spi_en,
  output logic [DATA_BITS-1:0]   spi_data_in,
  input  logic                   spi_ready,
  input  logic                   spi_valid,
  input  logic [DATA_BITS-1:0]   spi_data_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    FETCH   = 3'd2,
    LAUNCH  = 3'd3,
    WAIT_RX = 3'd4,
    DELIVER = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [1:0]                pend_q, pend_d;
  logic [1:0][LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]       rem_q, rem_d;
  logic                      g_q, g_d;
  logic                      rr_q, rr_d;
  logic                      sv_q, sv_d;
  logic [DATA_BITS-1:0]      txw_q, txw_d;
  logic [DATA_BITS-1:0]      rxw_q, rxw_d;
  logic [1:0]                rxv_q, rxv_d;
  logic [1:0]                done_q, done_d;

  logic [1:0]           gnt_oh;
  logic [1:0]           len_nz;
  logic [1:0]           start_ok;
  logic                 arb_g;
  logic                 active;
  logic                 last;
  logic                 sv_rise;
  logic [DATA_BITS-1:0] tx_sel;

  assign gnt_oh  = g_q ? 2'b10 : 2'b01;
  assign arb_g   = pend_q[rr_q] ? rr_q : ~rr_q;
  assign active  = state_q inside {FETCH, LAUNCH, WAIT_RX, DELIVER};
  assign last    = (rem_q == LEN_BITS'(1));
  assign sv_rise = spi_valid & ~sv_q;
  assign tx_sel  = g_q ? tx_data[2*DATA_BITS-1:DATA_BITS]
                       : tx_data[DATA_BITS-1:0];

  assign len_nz = {|req_len[2*LEN_BITS-1:LEN_BITS],
                   |req_len[LEN_BITS-1:0]};

  // busy falls in the done cycle so a same-cycle restart is accepted
  assign busy     = pend_q | ({2{active}} & gnt_oh & ~done_q);
  assign start_ok = req_start & ~busy & len_nz;

  assign tx_ready    = (state_q == FETCH) ? (tx_valid & gnt_oh) : 2'b00;
  assign spi_en      = (state_q == LAUNCH) & spi_ready;
  assign spi_data_in = txw_q;
  assign rx_data     = rxw_q;
  assign rx_valid    = rxv_q;
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    len_d   = len_q;
    rem_d   = rem_q;
    g_d     = g_q;
    rr_d    = rr_q;
    sv_d    = spi_valid;
    txw_d   = txw_q;
    rxw_d   = rxw_q;
    rxv_d   = 2'b00;
    done_d  = 2'b00;

    for (int k = 0; k < 2; k++) begin
      if (start_ok[k]) begin
        pend_d[k] = 1'b1;
        len_d[k]  = req_len[k*LEN_BITS +: LEN_BITS];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (|pend_q) state_d = ARB;
      end
      ARB: begin
        g_d           = arb_g;
        rr_d          = ~arb_g;
        pend_d[arb_g] = 1'b0;
        rem_d         = len_q[arb_g];
        state_d       = FETCH;
      end
      FETCH: begin
        if (tx_valid[g_q]) begin
          txw_d   = tx_sel;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (spi_ready) state_d = WAIT_RX;
      end
      WAIT_RX: begin
        if (sv_rise) begin
          rxw_d   = spi_data_out;
          rxv_d   = gnt_oh;
          done_d  = last ? gnt_oh : 2'b00;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        rem_d   = rem_q - LEN_BITS'(1);
        state_d = last ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      g_q     <= 1'b0;
      rr_q    <= 1'b0;
      sv_q    <= 1'b0;
      txw_q   <= '0;
      rxw_q   <= '0;
      rxv_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      sv_q    <= sv_d;
      txw_q   <= txw_d;
      rxw_q   <= rxw_d;
      rxv_q   <= rxv_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler with a behavioural
// spi_controller and two streaming requesters.
module tb_spi_txn_scheduler;

  localparam int FRAME = 4;

  typedef struct packed {
    logic       k;
    logic [7:0] d;
    logic       dn;
  } rxe_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] req_start;
  logic [7:0] req_len;
  logic       tv0, tv1;
  logic [7:0] td0, td1;
  logic [1:0] tx_valid;
  logic [15:0] tx_data;
  logic [1:0] tx_ready, rx_valid, busy, done;
  logic [7:0] rx_data, spi_data_in, spi_data_out;
  logic       spi_en, spi_ready, spi_valid;

  assign tx_valid = {tv1, tv0};
  assign tx_data  = {td1, td0};

  spi_txn_scheduler #(.DATA_BITS(8), .LEN_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_start(req_start), .req_len(req_len),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .done(done),
    .spi_en(spi_en), .spi_data_in(spi_data_in),
    .spi_ready(spi_ready), .spi_valid(spi_valid),
    .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_en     = 0;
  int n_rx     = 0;

  logic [7:0] exp_tx[$];
  rxe_t       exp_rx[$];
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  logic       tx_en0 = 1'b1;
  logic       fixed  = 1'b0;
  logic [7:0] slave_tx;
  bit         took0, took1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  task automatic push(input logic k, input logic [7:0] w,
                      input logic dn);
    rxe_t e;
    if (k) txq1.push_back(w);
    else   txq0.push_back(w);
    exp_tx.push_back(w);
    e.k  = k;
    e.d  = fixed ? 8'hA5 : ~w;
    e.dn = dn;
    exp_rx.push_back(e);
  endtask

  task automatic pulse(input logic [1:0] s, input logic [3:0] l0,
                       input logic [3:0] l1);
    @(posedge clk); #1;
    req_start = s;
    req_len   = {l1, l0};
    @(posedge clk); #1;
    req_start = 2'b00;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy == 2'b00 && exp_rx.size() == 0) break;
    end
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check({nm, "_rxq_empty"}, 32'(exp_rx.size()), 32'd0);
  endtask

  // requester TX feeders
  initial begin
    tv0 = 1'b0;
    td0 = 8'h00;
    forever begin
      @(negedge clk);
      took0 = tv0 && tx_ready[0];
      @(posedge clk); #1;
      if (took0 && txq0.size() > 0) void'(txq0.pop_front());
      tv0 = tx_en0 && (txq0.size() > 0);
      td0 = 8'h00;
      if (tv0) td0 = txq0[0];
    end
  end

  initial begin
    tv1 = 1'b0;
    td1 = 8'h00;
    forever begin
      @(negedge clk);
      took1 = tv1 && tx_ready[1];
      @(posedge clk); #1;
      if (took1 && txq1.size() > 0) void'(txq1.pop_front());
      tv1 = (txq1.size() > 0);
      td1 = 8'h00;
      if (tv1) td1 = txq1[0];
    end
  end

  // behavioural spi_controller
  initial begin
    spi_ready    = 1'b1;
    spi_valid    = 1'b0;
    spi_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (n_rst && spi_en) begin
        slave_tx = spi_data_in;
        @(posedge clk); #1 spi_ready = 1'b0;
        repeat (FRAME) @(posedge clk);
        #1;
        spi_valid    = 1'b1;
        spi_data_out = fixed ? 8'hA5 : ~slave_tx;
        @(posedge clk); #1;
        spi_valid = 1'b0;
        spi_ready = 1'b1;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents output
  initial begin
    rxe_t e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (spi_en) begin
          n_en++;
          if (exp_tx.size() == 0) flag("spi_en_unexpected");
          else check("spi_tx", 32'(spi_data_in),
                     32'(exp_tx.pop_front()));
        end
        if (rx_valid != 2'b00) begin
          n_rx++;
          if (exp_rx.size() == 0) flag("rx_valid_unexpected");
          else begin
            e = exp_rx.pop_front();
            check("rx_valid", 32'(rx_valid), e.k ? 32'd2 : 32'd1);
            check("rx_data", 32'(rx_data), 32'(e.d));
            check("done", 32'(done),
                  e.dn ? (e.k ? 32'd2 : 32'd1) : 32'd0);
          end
        end else if (done != 2'b00) begin
          flag("done_without_rx");
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, rx0, bad;
    n_rst     = 1'b0;
    req_start = 2'b00;
    req_len   = 8'h00;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spi_en", 32'(spi_en), 32'd0);
    check("rst_spi_data", 32'(spi_data_in), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // contention, pointer at 0: requester 0 first
    fixed = 1'b0;
    push(0, 8'h11, 0); push(0, 8'h22, 1);
    push(1, 8'h33, 0); push(1, 8'h44, 1);
    pulse(2'b11, 4'd2, 4'd2);
    check("cont1_busy", 32'(busy), 32'd3);
    wait_idle("cont1");
    check("cont1_en_cnt", 32'(n_en), 32'd4);
    check("cont1_rx_cnt", 32'(n_rx), 32'd4);

    // single transaction, fixed slave reply
    fixed = 1'b1;
    push(0, 8'hFA, 0); push(0, 8'hFB, 0); push(0, 8'hFC, 1);
    en0 = n_en;
    rx0 = n_rx;
    pulse(2'b01, 4'd3, 4'd0);
    check("single_busy", 32'(busy), 32'd1);
    wait_idle("single");
    check("single_en_cnt", 32'(n_en - en0), 32'd3);
    check("single_rx_cnt", 32'(n_rx - rx0), 32'd3);

    // contention, pointer now at 1: requester 1 first
    fixed = 1'b0;
    push(1, 8'h55, 0); push(1, 8'h66, 1);
    push(0, 8'h77, 0); push(0, 8'h88, 1);
    pulse(2'b11, 4'd2, 4'd2);
    wait_idle("cont2");

    // back-to-back restart in the done cycle
    push(1, 8'h9A, 1);
    push(1, 8'hB1, 0); push(1, 8'hB2, 1);
    pulse(2'b10, 4'd0, 4'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[1]) break;
    end
    check("b2b_done_seen", 32'(done[1]), 32'd1);
    check("b2b_busy_drop", 32'(busy[1]), 32'd0);
    req_start = 2'b10;
    req_len   = {4'd2, 4'd0};
    @(posedge clk); #1;
    req_start = 2'b00;
    @(negedge clk);
    check("b2b_idle", 32'(dut.state_q), 32'd0);
    check("b2b_busy", 32'(busy[1]), 32'd1);
    @(negedge clk);
    check("b2b_arb", 32'(dut.state_q), 32'd1);
    wait_idle("b2b");

    // TX stall for 20 cycles in FETCH
    tx_en0 = 1'b0;
    push(0, 8'hC3, 1);
    pulse(2'b01, 4'd1, 4'd0);
    @(negedge clk);
    @(negedge clk);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (dut.state_q != 3'd2 || spi_en || tx_ready != 2'b00)
        bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    tx_en0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_ready[0]) break;
    end
    check("stall_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    check("stall_launch", 32'(spi_en), 32'd1);
    wait_idle("stall");

    // zero-length start is dropped
    en0 = n_en;
    pulse(2'b01, 4'd0, 4'd0);
    check("len0_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("len0_busy_late", 32'(busy), 32'd0);
    check("len0_en_cnt", 32'(n_en - en0), 32'd0);

    // start while busy is ignored
    push(0, 8'hD1, 0); push(0, 8'hD2, 1);
    rx0 = n_rx;
    pulse(2'b01, 4'd2, 4'd0);
    repeat (3) @(negedge clk);
    check("rebusy_busy", 32'(busy), 32'd1);
    pulse(2'b01, 4'd3, 4'd0);
    wait_idle("rebusy");
    check("rebusy_rx_cnt", 32'(n_rx - rx0), 32'd2);
    repeat (3) @(negedge clk);
    check("rebusy_no_pend", 32'(busy), 32'd0);

    // reset while waiting for the RX word
    txq0.push_back(8'hE1);
    exp_tx.push_back(8'hE1);
    txq0.push_back(8'hE2);
    pulse(2'b01, 4'd2, 4'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (spi_en) break;
    end
    check("rstw_en", 32'(spi_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rstw_wait_rx", 32'(dut.state_q), 32'd4);
    n_rst = 1'b0;
    #1;
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_spi_en", 32'(spi_en), 32'd0);
    check("rstw_spi_data", 32'(spi_data_in), 32'd0);
    check("rstw_rx_valid", 32'(rx_valid), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    txq0.delete();
    repeat (10) @(negedge clk);
    n_rst = 1'b1;

    // clean transaction after reset
    fixed = 1'b0;
    rx0 = n_rx;
    push(1, 8'h5A, 1);
    pulse(2'b10, 4'd0, 4'd1);
    wait_idle("post_rst");
    check("post_rst_rx_cnt", 32'(n_rx - rx0), 32'd1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
